sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//   Shares the single external 8-bit SRAM port (sram_addr / sram_write_en / bidirectional sram_data)
//   between two requesters: M0 = control_unit LOAD/STORE path, M1 = secondary master (DMA/debug loader).
//   Round-robin arbitration, one transfer at a time, req/done handshake per master.
//   Sits between uC_8bits internals and the SRAM pins; owns the tristate on sram_data.
// PARAMETERS
//   ADDR_WIDTH  8  SRAM address width
//   DATA_WIDTH  8  SRAM data width
//   READ_LAT    1  cycles sram_addr is held before read data is sampled (legal range >= 1)
// PORTS
//   clk            in   1           system clock, all logic on rising edge
//   rst            in   1           synchronous reset, active-low (0 = reset)
//   m0_req         in   1           M0 transfer request, held until m0_done
//   m0_we          in   1           M0 direction: 1 = write, 0 = read
//   m0_addr        in   ADDR_WIDTH  M0 address, stable while m0_req=1
//   m0_wdata       in   DATA_WIDTH  M0 write data, stable while m0_req=1
//   m0_done        out  1           one-cycle pulse: M0 transfer complete
//   m0_rdata       out  DATA_WIDTH  M0 read data, valid in m0_done cycle, held until next M0 read
//   m1_req/m1_we/m1_addr/m1_wdata/m1_done/m1_rdata   same as M0, for M1
//   sram_addr      out  ADDR_WIDTH  SRAM address
//   sram_write_en  out  1           SRAM write strobe, also enables the sram_data driver
//   sram_data      inout DATA_WIDTH driven with latched wdata when sram_write_en=1, else 'z
//   busy           out  1           1 in any state except IDLE
//   owner          out  1           master owning current/last transfer (0 = M0, 1 = M1)
// BEHAVIOUR
//   - Clocking: one clock; reset is synchronous and active-low.
//   - Reset (rst=0 at an edge): state=IDLE, sram_addr=0, sram_write_en=0, sram_data='z, m*_done=0,
//     m*_rdata=0, busy=0, owner=0, rr_ptr=0 (M0 wins first tie). Reset mid-transfer aborts it, no done.
//   - FSM IDLE -> ACCESS -> DONE -> IDLE.
//     IDLE: sample m0_req/m1_req. None -> stay. One -> that master wins. Both -> rr_ptr wins.
//       On a grant: latch we/addr/wdata of winner, set owner, rr_ptr <= ~winner, go ACCESS.
//     ACCESS, write: exactly 1 cycle; sram_addr=latched addr, sram_write_en=1, sram_data=latched wdata.
//     ACCESS, read: READ_LAT cycles; sram_write_en=0, bus 'z; down-counter from READ_LAT-1;
//       on the last ACCESS cycle's edge capture sram_data into owner's rdata register.
//     DONE: owner's done=1 for exactly one cycle, sram_write_en=0; next state IDLE unconditionally.
//   - Latency from req sampled in IDLE (cycle t): write done at t+2; read done at t+1+READ_LAT.
//   - sram_addr holds its last value outside ACCESS (no glitch to 0); sram_write_en only high in write ACCESS.
//   - Handshake: requester drops req on the edge ending its done cycle; req still high in the following
//     IDLE is a new transfer. Inputs are latched at grant; changes after grant are ignored.
//   - Requester dropping req after grant: transfer still completes, done still pulses.
//   - Non-owner's rdata never changes; never both done outputs high in the same cycle.
//   - Fairness: with both req held continuously, grants alternate M0, M1, M0, ...; each grant is
//     separated by one IDLE cycle.
//   - Counter width: $clog2(READ_LAT)+1 bits; no arithmetic on address/data (pass-through).
// STRUCTURE
//   - Package sram_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and master IDs
//     (M0_ID=1'b0, M1_ID=1'b1).
//   - Sub-module rr_arb2: combinational 2-way round-robin picker (req[1:0], rr_ptr -> grant_valid, winner).
//   - Top: FSM, latch registers, latency counter, tristate assign.
// TESTING
//   1. Reset: hold rst=0 3 cycles with m0_req=1 -> busy=0, sram_write_en=0, sram_data='z, no done.
//      Release rst -> M0 granted next IDLE.
//   2. M0 write addr=0x3C data=0xA5 at t -> sram_write_en=1 with sram_addr=0x3C and sram_data=0xA5
//      at t+1 only; m0_done at t+2.
//   3. M1 read addr=0x3C, bench model returns 0xA5, READ_LAT=1 -> m1_done at t+2 with m1_rdata=0xA5;
//      m0_rdata unchanged. Repeat with READ_LAT=3 -> done at t+4.
//   4. Both req held continuously from reset for 6 grants -> owner sequence 0,1,0,1,0,1; no overlap
//      of done pulses; sram_write_en never high while bench drives bus.
//   5. Reset asserted during a READ_LAT=3 read ACCESS -> next cycle state IDLE, no m*_done,
//      rdata unchanged (0).
//   6. M0 changes m0_addr 0x10 -> 0x20 one cycle after grant -> access uses 0x10; M0 drops req
//      during ACCESS -> m0_done still pulses once.

Source files
------------

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_arb_pkg : state encoding and master IDs shared by the SRAM arbiter
// Revision     : 1.0
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2  : combinational two-way round-robin picker
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       grant_valid,
  output logic       winner
);

  always_comb begin
    grant_valid = |req;
    winner      = M0_ID;
    case (req)
      2'b01:   winner = M0_ID;
      2'b10:   winner = M1_ID;
      2'b11:   winner = rr_ptr;  // contention: the pointer decides
      default: winner = M0_ID;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_arbiter : shares one external SRAM port between two req/done masters
// Revision     : 1.0
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_write_en,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  busy,
  output logic                  owner
);

  localparam int             CNT_W    = $clog2(READ_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  owner_q, owner_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  logic grant_valid;
  logic winner;

  rr_arb2 u_rr_arb2 (
    .req         ({m1_req, m0_req}),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          we_d     = (winner == M1_ID) ? m1_we    : m0_we;
          addr_d   = (winner == M1_ID) ? m1_addr  : m0_addr;
          wdata_d  = (winner == M1_ID) ? m1_wdata : m0_wdata;
          owner_d  = winner;
          rr_ptr_d = ~winner;
          cnt_d    = CNT_INIT;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          // last read cycle: the bus has been stable for READ_LAT cycles
          if (owner_q == M1_ID) begin
            m1_rdata_d = sram_data;
          end else begin
            m0_rdata_d = sram_data;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= M0_ID;
      rr_ptr_q   <= M0_ID;
      cnt_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // addr_q only loads on a grant, so the pins hold the last address between transfers
  assign sram_addr     = addr_q;
  assign sram_write_en = (state_q == ST_ACCESS) && we_q;
  assign sram_data     = sram_write_en ? wdata_q : {DATA_WIDTH{1'bz}};

  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign m0_done  = (state_q == ST_DONE) && (owner_q == M0_ID);
  assign m1_done  = (state_q == ST_DONE) && (owner_q == M1_ID);
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
`default_nettype wire
